// File: rtl/ram16_arbiter.sv
// ram16_arbiter: shares one RAM16 between two requesters using a registered IDLE -> ACC -> DONE sequence.
// Define RAM16_ARB_RR_EN for round-robin conflict resolution; if it is undefined, port 0 has fixed priority.
module ram16_arbiter #(
  parameter int AW = 2,
  parameter int DW = 32,
  parameter int NB = DW / 8
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          p0_req,
  input  logic [NB-1:0] p0_we,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_ack,
  output logic [DW-1:0] p0_rdata,
  input  logic          p1_req,
  input  logic [NB-1:0] p1_we,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_ack,
  output logic [DW-1:0] p1_rdata,
  output logic          ram_en,
  output logic [NB-1:0] ram_we,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic          sel_q, sel_d;
  logic          last_q, last_d;
  logic          p0_ack_q, p0_ack_d;
  logic          p1_ack_q, p1_ack_d;
  logic [DW-1:0] p0_rdata_q, p0_rdata_d;
  logic [DW-1:0] p1_rdata_q, p1_rdata_d;
  logic          grant_s;

  // Winner among current requests; only meaningful while some request is high.
  always_comb begin
    grant_s = 1'b0;
    if (p0_req && p1_req) begin
`ifdef RAM16_ARB_RR_EN
      grant_s = ~last_q;
`else
      grant_s = 1'b0;
`endif
    end else if (p1_req) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Sequencer next-state: acks default low so they only live for the DONE cycle.
  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    last_d     = last_q;
    p0_ack_d   = 1'b0;
    p1_ack_d   = 1'b0;
    p0_rdata_d = p0_rdata_q;
    p1_rdata_d = p1_rdata_q;
    case (state_q)
      IDLE: begin
        if (p0_req || p1_req) begin
          sel_d   = grant_s;
          last_d  = grant_s;
          state_d = ACC;
        end else begin
          state_d = IDLE;
        end
      end
      ACC: begin
        if (sel_q) begin
          p1_rdata_d = ram_rdata;
          p1_ack_d   = 1'b1;
        end else begin
          p0_rdata_d = ram_rdata;
          p0_ack_d   = 1'b1;
        end
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and result registers; reset also kills an in-flight RAM access.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      sel_q      <= 1'b0;
      last_q     <= 1'b1;
      p0_ack_q   <= 1'b0;
      p1_ack_q   <= 1'b0;
      p0_rdata_q <= {DW{1'b0}};
      p1_rdata_q <= {DW{1'b0}};
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      last_q     <= last_d;
      p0_ack_q   <= p0_ack_d;
      p1_ack_q   <= p1_ack_d;
      p0_rdata_q <= p0_rdata_d;
      p1_rdata_q <= p1_rdata_d;
    end
  end

  // RAM pins decode from registered state only, so the enable cannot glitch.
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = {NB{1'b0}};
    ram_addr  = {AW{1'b0}};
    ram_wdata = {DW{1'b0}};
    if (state_q == ACC) begin
      ram_en = 1'b1;
      if (sel_q) begin
        ram_we    = p1_we;
        ram_addr  = p1_addr;
        ram_wdata = p1_wdata;
      end else begin
        ram_we    = p0_we;
        ram_addr  = p0_addr;
        ram_wdata = p0_wdata;
      end
    end else begin
      ram_en = 1'b0;
    end
  end

  assign busy     = (state_q != IDLE);
  assign p0_ack   = p0_ack_q;
  assign p1_ack   = p1_ack_q;
  assign p0_rdata = p0_rdata_q;
  assign p1_rdata = p1_rdata_q;

endmodule
